// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard sequencer states, register-zero index
// and the NOP that IF/ID loads when its flush control is asserted.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    REDIRECT   = 2'd2,
    MEM_WAIT   = 2'd3
  } hz_state_t;

  localparam logic [4:0]  REG_ZERO = 5'd0;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID source operands and a load in EX.
// Purely combinational so a forwarding unit can reuse the same match logic.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] Ra_ID,
  input  logic [4:0] Rb_ID,
  input  logic       UseRa_ID,
  input  logic       UseRb_ID,
  input  logic [4:0] Rd_EX,
  input  logic       MemRead_EX,
  output logic       load_use
);

  logic match_a;
  logic match_b;

  assign match_a  = UseRa_ID && (Ra_ID == Rd_EX);
  assign match_b  = UseRb_ID && (Rb_ID == Rd_EX);
  // x0 is hardwired to zero, so a load targeting it never produces a hazard
  assign load_use = MemRead_EX && (Rd_EX != REG_ZERO) && (match_a || match_b);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; state advances on the falling
// clock edge. Define HAZARD_PERF_CNT_EN to add the Stall_cnt/Flush_cnt counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [4:0]  Ra_ID,
  input  logic [4:0]  Rb_ID,
  input  logic        UseRa_ID,
  input  logic        UseRb_ID,
  input  logic [4:0]  Rd_EX,
  input  logic        MemRead_EX,
  input  logic        Redirect_EX,
  input  logic        Mem_busy,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Write,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Write,
  output logic        Mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] Stall_cnt,
  output logic [31:0] Flush_cnt
`endif
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LIM  = 8'(MEM_TIMEOUT);
  localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  hz_state_t  state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic [7:0] busy_cnt, busy_cnt_nxt;
  logic       timeout_q, timeout_nxt;
  logic       load_use;
  logic       stall_evt;
  logic       redir_evt;

  hazard_detect u_hazard_detect (
    .Ra_ID      (Ra_ID),
    .Rb_ID      (Rb_ID),
    .UseRa_ID   (UseRa_ID),
    .UseRb_ID   (UseRb_ID),
    .Rd_EX      (Rd_EX),
    .MemRead_EX (MemRead_EX),
    .load_use   (load_use)
  );

  always_ff @(negedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= RUN;
      flush_cnt <= '0;
      busy_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      busy_cnt  <= busy_cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    busy_cnt_nxt  = busy_cnt;
    timeout_nxt   = timeout_q;
    stall_evt     = 1'b0;
    redir_evt     = 1'b0;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Write   = 1'b1;
    ID_EX_Flush   = 1'b0;
    EX_MEM_Write  = 1'b1;
    Mem_timeout   = timeout_q;

    if (Reset) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Write  = 1'b0;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Write = 1'b0;
    end else if (Mem_busy) begin
      // Freeze everything; pending redirect/load-use is re-presented by the
      // frozen registers once the memory is ready again.
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      state_nxt     = MEM_WAIT;
      flush_cnt_nxt = '0;
      busy_cnt_nxt  = sat_inc8(busy_cnt);
      stall_evt     = 1'b1;
      if (busy_cnt_nxt >= TIMEOUT_LIM) begin
        timeout_nxt = 1'b1;
      end
    end else begin
      busy_cnt_nxt = '0;
      state_nxt    = RUN;
      if (Redirect_EX) begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
        PC_Write    = 1'b1;
        redir_evt   = 1'b1;
        if (MULTI_FLUSH) begin
          state_nxt     = REDIRECT;
          flush_cnt_nxt = FLUSH_RELOAD;
        end else begin
          flush_cnt_nxt = '0;
        end
      end else if (state == REDIRECT) begin
        // IF/ID holds a NOP here, so load-use is not evaluated
        IF_ID_Flush   = (flush_cnt != 3'd0);
        flush_cnt_nxt = (flush_cnt != 3'd0) ? flush_cnt - 3'd1 : 3'd0;
        state_nxt     = (flush_cnt > 3'd1) ? REDIRECT : RUN;
      end else if ((state != LOAD_STALL) && load_use) begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
        state_nxt   = LOAD_STALL;
        stall_evt   = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(negedge CLK or posedge Reset) begin
    if (Reset) begin
      Stall_cnt <= '0;
      Flush_cnt <= '0;
    end else begin
      if (stall_evt) Stall_cnt <= Stall_cnt + 32'd1;
      if (redir_evt) Flush_cnt <= Flush_cnt + 32'd1;
    end
  end
`else
  logic unused_perf_evt;
  assign unused_perf_evt = stall_evt ^ redir_evt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven bench for pipeline_hazard_ctrl with a scoreboard queue of
// expected output vectors; FLUSH_CYCLES=3, MEM_TIMEOUT=64.
module tb_pipeline_hazard_ctrl;

  logic       CLK, Reset;
  logic [4:0] Ra_ID, Rb_ID, Rd_EX;
  logic       UseRa_ID, UseRb_ID, MemRead_EX, Redirect_EX, Mem_busy;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
  logic       EX_MEM_Write, Mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] Stall_cnt, Flush_cnt;
`endif

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(64)) dut (
    .CLK(CLK), .Reset(Reset),
    .Ra_ID(Ra_ID), .Rb_ID(Rb_ID), .UseRa_ID(UseRa_ID), .UseRb_ID(UseRb_ID),
    .Rd_EX(Rd_EX), .MemRead_EX(MemRead_EX), .Redirect_EX(Redirect_EX),
    .Mem_busy(Mem_busy),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Write(EX_MEM_Write), .Mem_timeout(Mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_cnt(Stall_cnt), .Flush_cnt(Flush_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, Mem_timeout}
  localparam logic [6:0] E_RUN  = 7'b1101010;
  localparam logic [6:0] E_LU   = 7'b0001110;
  localparam logic [6:0] E_RDR  = 7'b1111110;
  localparam logic [6:0] E_TAIL = 7'b1111010;
  localparam logic [6:0] E_BSY  = 7'b0000000;
  localparam logic [6:0] E_RST  = 7'b0010100;
  localparam logic [6:0] E_TO   = 7'b0000001;

  typedef struct packed {
    logic [4:0] ra;
    logic [4:0] rb;
    logic       usea;
    logic       useb;
    logic [4:0] rd;
    logic       memrd;
    logic       redir;
    logic       busy;
    logic [6:0] exp;
  } vec_t;

  localparam int NV = 27;
  vec_t       tbl [NV];
  logic [6:0] sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [6:0] outs;

  assign outs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
                 EX_MEM_Write, Mem_timeout};

  function automatic vec_t mk(input int ra, input int rb, input bit usea,
                              input bit useb, input int rd, input bit memrd,
                              input bit redir, input bit busy,
                              input logic [6:0] exp);
    vec_t v;
    v.ra = 5'(ra); v.rb = 5'(rb); v.usea = usea; v.useb = useb;
    v.rd = 5'(rd); v.memrd = memrd; v.redir = redir; v.busy = busy;
    v.exp = exp;
    return v;
  endfunction

  task automatic compare(input string name, input logic [6:0] exp);
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs %b, expected %b", name, outs, exp);
    end
    if (!Reset) begin
      n_checks++;
      if (ID_EX_Flush && !ID_EX_Write) begin
        n_fail++;
        $display("FAIL %s_idex_excl: flush %b write %b, expected not both", name,
                 ID_EX_Flush, ID_EX_Write);
      end
    end
  endtask

  // Drive one cycle of inputs right after the active (falling) edge, check mid-cycle.
  task automatic step(input vec_t v, input string name);
    Ra_ID = v.ra; Rb_ID = v.rb; UseRa_ID = v.usea; UseRb_ID = v.useb;
    Rd_EX = v.rd; MemRead_EX = v.memrd; Redirect_EX = v.redir; Mem_busy = v.busy;
    sb_q.push_back(v.exp);
    @(posedge CLK); #1;
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty, got %b", name, outs);
    end else begin
      compare(name, sb_q.pop_front());
    end
    @(negedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t, expected end before 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        ra rb ua ub rd mr rdr bsy exp
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
    tbl[1]  = mk(5, 0, 1, 0, 5, 1, 0, 0, E_LU);
    tbl[2]  = mk(5, 0, 1, 0, 5, 0, 0, 0, E_RUN);
    tbl[3]  = mk(1, 9, 1, 1, 9, 1, 0, 0, E_LU);
    tbl[4]  = mk(1, 9, 1, 1, 9, 1, 0, 0, E_RUN);
    tbl[5]  = mk(0, 3, 1, 0, 0, 1, 0, 0, E_RUN);
    tbl[6]  = mk(2, 7, 1, 0, 7, 1, 0, 0, E_RUN);
    tbl[7]  = mk(5, 0, 1, 0, 5, 0, 0, 0, E_RUN);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0, E_RDR);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, E_TAIL);
    tbl[10] = mk(6, 0, 1, 0, 6, 1, 0, 0, E_TAIL);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 0, E_RDR);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, E_TAIL);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 0, E_RDR);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, E_TAIL);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, E_TAIL);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
    tbl[18] = mk(4, 0, 1, 0, 4, 1, 1, 1, E_BSY);
    tbl[19] = mk(4, 0, 1, 0, 4, 1, 1, 1, E_BSY);
    tbl[20] = mk(4, 0, 1, 0, 4, 1, 1, 0, E_RDR);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, E_TAIL);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 1, E_BSY);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 1, E_BSY);
    tbl[25] = mk(0, 8, 0, 1, 8, 1, 0, 0, E_LU);
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN);

    Reset = 1'b1;
    Ra_ID = '0; Rb_ID = '0; Rd_EX = '0;
    UseRa_ID = 0; UseRb_ID = 0; MemRead_EX = 0; Redirect_EX = 0; Mem_busy = 0;
    #3;
    compare("reset_outputs", E_RST);
    @(negedge CLK); #1;
    Reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Memory timeout: 64 busy cycles; flag set by the 64th busy edge and sticky.
    for (int i = 1; i <= 64; i++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 1, E_BSY), $sformatf("busy%0d", i));
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN | E_TO), "timeout_set");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN | E_TO), "timeout_sticky");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, E_RDR | E_TO), "timeout_redir");

    // Now in REDIRECT with flush counter 2; assert reset mid-cycle.
    Redirect_EX = 1'b0;
    #2 Reset = 1'b1;
    #1 compare("reset_async", E_RST);
    @(negedge CLK); #1;
    compare("reset_held", E_RST);
    Reset = 1'b0;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN), "post_reset_run");
    step(mk(3, 0, 1, 0, 3, 1, 0, 0, E_LU), "post_reset_lu");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN), "post_reset_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Watches ID operands, the ID/EX control outputs (Rd_EX, MemRead_EX, Branch/Jump resolution) and the data-memory busy line.
- Drives write-enables and bubble-insert (flush) controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Sole owner of the decision to hold or bubble the ID/EX register.

Parameters:
- FLUSH_CYCLES, 1, cycles IF/ID is flushed after a taken redirect (>1 for multi-cycle fetch); legal 1..7.
- MEM_TIMEOUT, 64, consecutive Mem_busy cycles before Mem_timeout is raised; legal 2..255.

Ports:
- CLK  in  1  pipeline clock; state updates on falling edge, same edge as the pipeline registers.
- Reset  in  1  asynchronous, active-high reset.
- Ra_ID  in  5  rs1 index in ID.
- Rb_ID  in  5  rs2 index in ID.
- UseRa_ID  in  1  ID instruction reads rs1.
- UseRb_ID  in  1  ID instruction reads rs2.
- Rd_EX  in  5  destination index in EX.
- MemRead_EX  in  1  EX instruction is a load.
- Redirect_EX  in  1  taken branch or jump resolved in EX.
- Mem_busy  in  1  data memory not ready this cycle.
- PC_Write  out  1  PC may update.
- IF_ID_Write  out  1  IF/ID may load.
- IF_ID_Flush  out  1  IF/ID loads a NOP.
- ID_EX_Write  out  1  ID/EX may load.
- ID_EX_Flush  out  1  ID/EX loads all-zero controls (bubble).
- EX_MEM_Write  out  1  EX/MEM may load.
- Mem_timeout  out  1  sticky error flag.

Behaviour:
- States: RUN, LOAD_STALL, REDIRECT, MEM_WAIT. 3-bit flush counter, 8-bit busy counter.
- Outputs are combinational from state + inputs; no added latency. Defaults: all *_Write=1, all *_Flush=0, Mem_timeout = its register.
- Reset asserted: state=RUN, counters=0, Mem_timeout=0. Outputs during reset: all *_Write=0, IF_ID_Flush=1, ID_EX_Flush=1.
- Priority per cycle is Mem_busy > Redirect_EX > load-use.
- Mem_busy=1 (any state):
  - PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Write=0, no flushes.
  - Next state MEM_WAIT; busy counter increments, saturating at 255.
  - When the counter reaches MEM_TIMEOUT, Mem_timeout sets; it clears only on Reset.
  - A Redirect_EX or load-use seen during busy is ignored. Frozen registers re-present it when busy drops.
- MEM_WAIT with Mem_busy=0: busy counter clears, then evaluate as RUN in the same cycle.
- Redirect_EX=1 (not busy):
  - IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1.
  - If FLUSH_CYCLES>1: state REDIRECT, flush counter = FLUSH_CYCLES-1.
- REDIRECT:
  - IF_ID_Flush=1 while counter>0; decrement each cycle; return to RUN on 1->0.
  - A new Redirect_EX reloads the counter.
  - Load-use is suppressed because IF/ID holds a NOP.
- Load-use: MemRead_EX & Rd_EX!=0 & ((UseRa_ID & Ra_ID==Rd_EX) | (UseRb_ID & Rb_ID==Rd_EX)).
  - PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; state LOAD_STALL.
- LOAD_STALL: exactly one cycle. The bubble makes MEM_READ_EX=0, so no re-trigger. Next state RUN.
- Register x0 never causes a stall.
- ID_EX_Flush and ID_EX_Write=0 are never both active.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs Stall_cnt[31:0] (load-use + mem-wait cycles) and Flush_cnt[31:0] (redirect events). Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Shared package pipeline_pkg holds:
  - state enum hz_state_t {RUN, LOAD_STALL, REDIRECT, MEM_WAIT};
  - constant REG_ZERO=5'd0;
  - NOP instruction constant used by the IF_ID_Flush consumer.
- One sub-module: hazard_detect (pure combinational load-use compare), reusable by a future forwarding unit.

Test Plan:
- Load-use: MemRead_EX=1, Rd_EX=5, Ra_ID=5, UseRa_ID=1 -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle (MemRead_EX=0) all Write=1.
- x0 / unused operand: Rd_EX=0 with Ra_ID=0, or Rd_EX=7 with Rb_ID=7 and UseRb_ID=0 -> no stall.
- Redirect with FLUSH_CYCLES=3: Redirect_EX pulse -> IF_ID_Flush high 3 cycles, ID_EX_Flush high 1 cycle; second redirect on cycle 2 restarts the count.
- Simultaneous Mem_busy=1, Redirect_EX=1 and load-use -> all Write=0, no flush. Release busy -> redirect flush occurs that cycle.
- Mem_busy held 64 cycles (MEM_TIMEOUT=64) -> Mem_timeout rises on cycle 64 and stays after busy drops; clears only on Reset.
- Reset asserted mid-REDIRECT (counter=2) -> immediate async return to RUN, counters 0, reset output pattern; after deassert, normal RUN.
